std_sram_sp_param_init: RTL and testbench

- Parametrised single-port SRAM block with byte-masked writes, a valid/ready request/response handshake and a hardware init sweep after reset.
- Successor to the fixed 64-deep x 128-bit single-port wrappers.
- Used as the generic storage primitive for caches, TLB arrays and queues.
- The array is behavioural (inferred), so depth and width are free parameters.

---
 rtl/std_sram_sp_param_init.sv | 126 ++++++++++++
 tb/tb_std_sram_sp_param_init.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/std_sram_sp_param_init.sv
// Parametrised single-port SRAM with byte-masked writes, valid/ready request and
// response handshakes, and an optional post-reset sweep that fills every entry with
// INIT_VALUE.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   init_busy  high while the init sweep runs
//   req_*      request channel (valid/ready, we, addr, byte mask, write data)
//   rsp_*      read response channel (valid/ready, read data)
module std_sram_sp_param_init #(
   parameter int unsigned       DEPTH      = 64,
   parameter int unsigned       WIDTH      = 128,
   parameter int unsigned       INIT_EN    = 1,
   parameter logic [WIDTH-1:0]  INIT_VALUE = '0,
   localparam int unsigned      AW         = $clog2(DEPTH),
   localparam int unsigned      MW         = WIDTH / 8
) (
   input  logic              clk,
   input  logic              resetn,
   output logic              init_busy,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [AW-1:0]     req_addr,
   input  logic [MW-1:0]     req_mask,
   input  logic [WIDTH-1:0]  req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WIDTH-1:0]  rsp_rdata
);

   // Parameter sanity checks at elaboration
   if ((WIDTH % 8) != 0 || WIDTH == 0) begin : g_bad_width
      $error("std_sram_sp_param_init: WIDTH must be a non-zero multiple of 8");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $error("std_sram_sp_param_init: DEPTH must be at least 2");
   end

   localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam state_t RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

   state_t             state_q, state_d;
   logic [AW-1:0]      init_cnt_q;
   logic [WIDTH-1:0]   mem [DEPTH];

   logic               acc;
   logic               in_range;
   logic               mem_we;
   logic [AW-1:0]      mem_addr;
   logic [MW-1:0]      mem_mask;
   logic [WIDTH-1:0]   mem_wdata;

   // Accept only in RUN and when the response slot is free or draining
   assign req_ready = resetn && (state_q == ST_RUN) && (!rsp_valid || rsp_ready);
   assign acc       = req_valid && req_ready;
   assign in_range  = {1'b0, req_addr} < DEPTH_W;

   // Next-state logic: sweep ends after writing the last entry
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: if (init_cnt_q == LAST_IDX) state_d = ST_RUN;
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   // Array write port: sweep has priority, otherwise accepted in-range writes
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = req_addr;
      mem_mask  = req_mask;
      mem_wdata = req_wdata;
      if (state_q == ST_INIT) begin
         mem_we    = resetn;
         mem_addr  = init_cnt_q;
         mem_mask  = '1;
         mem_wdata = INIT_VALUE;
      end else if (acc && req_we && in_range) begin
         mem_we    = 1'b1;
      end
   end

   // State register, sweep counter and busy flag
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= RST_STATE;
         init_cnt_q <= '0;
         init_busy  <= (INIT_EN != 0);
      end else begin
         state_q    <= state_d;
         init_busy  <= (state_d == ST_INIT);
         if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + AW'(1);
      end
   end

   // Storage array, not reset; byte lanes gated by the mask
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < int'(MW); b++) begin
            if (mem_mask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   // Response hold register: loads only on an accepted read, so data stays
   // stable under backpressure regardless of later array activity
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else if (acc && !req_we) begin
         rsp_valid <= 1'b1;
         rsp_rdata <= in_range ? mem[req_addr] : '0;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_std_sram_sp_param_init.sv
// Bench for std_sram_sp_param_init: a 64x128 instance (sweep, table vectors,
// random traffic vs. a reference model, mid-sweep reset) and a 48x32 instance
// (out-of-range addressing).
module tb_std_sram_sp_param_init;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 64 x 128 instance
   logic          resetn, init_busy, req_valid, req_ready, req_we, rsp_valid, rsp_ready;
   logic [5:0]    req_addr;
   logic [15:0]   req_mask;
   logic [127:0]  req_wdata, rsp_rdata;

   std_sram_sp_param_init #(.DEPTH(64), .WIDTH(128), .INIT_EN(1), .INIT_VALUE('0)) dut64 (
      .clk(clk), .resetn(resetn), .init_busy(init_busy),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata));

   // 48 x 32 instance
   logic          b_resetn, b_init_busy, b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
   logic [5:0]    b_req_addr;
   logic [3:0]    b_req_mask;
   logic [31:0]   b_req_wdata, b_rsp_rdata;

   localparam logic [31:0] B_INIT = 32'h5A5A_C3C3;

   std_sram_sp_param_init #(.DEPTH(48), .WIDTH(32), .INIT_EN(1), .INIT_VALUE(B_INIT)) dut48 (
      .clk(clk), .resetn(b_resetn), .init_busy(b_init_busy),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_addr(b_req_addr), .req_mask(b_req_mask), .req_wdata(b_req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic          v, we;
      logic [5:0]    addr;
      logic [15:0]   mask;
      logic [127:0]  wdata;
      logic          rr;
      logic          exp_ready, exp_valid;
      logic [127:0]  exp_rdata;
   } vec_t;

   vec_t          tbl[$];
   logic [127:0]  model [64];
   logic [127:0]  q[$];

   task automatic add(input logic v, input logic we, input logic [5:0] a, input logic [15:0] m,
                      input logic [127:0] d, input logic rr, input logic er, input logic ev,
                      input logic [127:0] ed);
      vec_t t;
      t.v = v; t.we = we; t.addr = a; t.mask = m; t.wdata = d; t.rr = rr;
      t.exp_ready = er; t.exp_valid = ev; t.exp_rdata = ed;
      tbl.push_back(t);
   endtask

   function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] d,
                                          input logic [15:0] m);
      logic [127:0] r;
      r = old;
      for (int b = 0; b < 16; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Counts cycles of init_busy after release; the port must stay idle throughout
   task automatic count_sweep(output int n);
      n = 0;
      while (init_busy && n < 300) begin
         chk("sweep_req_ready", 128'(req_ready), 128'(0));
         chk("sweep_rsp_valid", 128'(rsp_valid), 128'(0));
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int            n;
      logic          exp_rdy;
      logic [127:0]  ones;
      ones = '1;

      resetn = 1'b0; b_resetn = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_mask = '0; req_wdata = '0; rsp_ready = 1'b1;
      b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_mask = '0; b_req_wdata = '0;
      b_rsp_ready = 1'b1;
      for (int i = 0; i < 64; i++) dut64.mem[i] = {16{8'hA5}};

      repeat (3) @(negedge clk);
      chk("rst_init_busy", 128'(init_busy), 128'(1));
      chk("rst_req_ready", 128'(req_ready), 128'(0));
      chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("rst_rsp_rdata", rsp_rdata, 128'(0));

      // Initial sweep: exactly 64 busy cycles
      resetn = 1'b1;
      count_sweep(n);
      chk("sweep_len", 128'(n), 128'(64));
      for (int i = 0; i < 64; i++) model[i] = '0;

      // Directed vectors; outputs observed reflect the previous edge
      add(1,0, 0,16'h0,0,1, 1,0,0);
      add(1,0,31,16'h0,0,1, 1,1,0);
      add(1,0,63,16'h0,0,1, 1,1,0);
      add(0,0, 0,16'h0,0,1, 1,1,0);
      add(1,1, 5,16'hFFFF,ones,1, 1,0,0);
      add(1,1, 5,16'h0005,128'h00CD00AB,1, 1,0,0);
      add(1,0, 5,16'h0,0,1, 1,0,0);
      add(0,0, 0,16'h0,0,1, 1,1,{{13{8'hFF}},24'hCDFFAB});
      add(1,1, 8,16'hFFFF,128'h8888,1, 1,0,0);
      add(1,1, 9,16'hFFFF,128'h9999,1, 1,0,0);
      add(1,1, 1,16'hFFFF,128'h1111,1, 1,0,0);
      add(1,1, 2,16'hFFFF,128'h2222,1, 1,0,0);
      add(1,0, 1,16'h0,0,0, 1,0,0);
      add(1,0, 2,16'h0,0,0, 0,1,128'h1111);
      add(1,0, 2,16'h0,0,0, 0,1,128'h1111);
      add(1,0, 2,16'h0,0,0, 0,1,128'h1111);
      add(1,0, 2,16'h0,0,1, 1,1,128'h1111);
      add(0,0, 0,16'h0,0,0, 0,1,128'h2222);
      add(0,0, 0,16'h0,0,1, 1,1,128'h2222);
      add(1,1, 7,16'hFFFF,128'h1234,1, 1,0,0);
      add(1,0, 7,16'h0,0,1, 1,0,0);
      add(1,0, 8,16'h0,0,1, 1,1,128'h1234);
      add(1,0, 9,16'h0,0,1, 1,1,128'h8888);
      add(0,0, 0,16'h0,0,1, 1,1,128'h9999);
      add(1,1, 7,16'h0000,ones,1, 1,0,0);
      add(1,0, 7,16'h0,0,1, 1,0,0);
      add(0,0, 0,16'h0,0,1, 1,1,128'h1234);
      add(0,0, 0,16'h0,0,1, 1,0,0);

      foreach (tbl[k]) begin
         req_valid = tbl[k].v; req_we = tbl[k].we; req_addr = tbl[k].addr;
         req_mask = tbl[k].mask; req_wdata = tbl[k].wdata; rsp_ready = tbl[k].rr;
         #1;
         chk($sformatf("vec%0d_req_ready", k), 128'(req_ready), 128'(tbl[k].exp_ready));
         chk($sformatf("vec%0d_rsp_valid", k), 128'(rsp_valid), 128'(tbl[k].exp_valid));
         if (tbl[k].exp_valid) chk($sformatf("vec%0d_rsp_rdata", k), rsp_rdata, tbl[k].exp_rdata);
         if (tbl[k].v && tbl[k].we && tbl[k].exp_ready)
            model[tbl[k].addr] = merge(model[tbl[k].addr], tbl[k].wdata, tbl[k].mask);
         @(negedge clk);
      end

      // Random traffic against the reference model (pending-response queue)
      for (int i = 0; i < 400; i++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_we    = 1'($urandom_range(0, 1));
         req_addr  = 6'($urandom_range(0, 63));
         req_mask  = 16'($urandom);
         req_wdata = {$urandom, $urandom, $urandom, $urandom};
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         exp_rdy = (q.size() == 0) || rsp_ready;
         chk("rnd_req_ready", 128'(req_ready), 128'(exp_rdy));
         chk("rnd_rsp_valid", 128'(rsp_valid), 128'(q.size() != 0));
         if (q.size() != 0) chk("rnd_rsp_rdata", rsp_rdata, q[0]);
         if (q.size() != 0 && rsp_ready) void'(q.pop_front());
         if (req_valid && exp_rdy) begin
            if (req_we) model[req_addr] = merge(model[req_addr], req_wdata, req_mask);
            else        q.push_back(model[req_addr]);
         end
         @(negedge clk);
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      repeat (2) @(negedge clk);

      // Reset, partial sweep, reset again mid-sweep, then a full restart
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst2_rsp_rdata", rsp_rdata, 128'(0));
      chk("rst2_init_busy", 128'(init_busy), 128'(1));
      resetn = 1'b1;
      repeat (20) @(negedge clk);
      chk("mid_busy_before", 128'(init_busy), 128'(1));
      resetn = 1'b0;
      #1;
      chk("mid_rst_ready", 128'(req_ready), 128'(0));
      chk("mid_rst_rsp_valid", 128'(rsp_valid), 128'(0));
      repeat (2) @(negedge clk);
      chk("mid_rst_busy", 128'(init_busy), 128'(1));
      resetn = 1'b1;
      count_sweep(n);
      chk("mid_sweep_len", 128'(n), 128'(64));
      req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd7;
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("resweep_rsp_valid", 128'(rsp_valid), 128'(1));
      chk("resweep_rdata", rsp_rdata, 128'(0));

      // Out-of-range addressing on the 48-deep instance
      b_resetn = 1'b1;
      n = 0;
      while (b_init_busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("b_sweep_len", 128'(n), 128'(48));
      b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 6'd50; b_req_mask = 4'hF; b_req_wdata = 32'hFFFF;
      #1;
      chk("b_wr_ready", 128'(b_req_ready), 128'(1));
      @(negedge clk);
      b_req_we = 1'b0;
      #1;
      chk("b_rd50_ready", 128'(b_req_ready), 128'(1));
      @(negedge clk);
      b_req_addr = 6'd18;
      #1;
      chk("b_rd50_valid", 128'(b_rsp_valid), 128'(1));
      chk("b_rd50_data", 128'(b_rsp_rdata), 128'(0));
      @(negedge clk);
      b_req_valid = 1'b0;
      #1;
      chk("b_rd18_valid", 128'(b_rsp_valid), 128'(1));
      chk("b_rd18_data", 128'(b_rsp_rdata), 128'(B_INIT));
      @(negedge clk);
      chk("b_idle_valid", 128'(b_rsp_valid), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
